axis_rate_policer: RTL and testbench

AXI4-Stream ingress policer: the enforcement counterpart of `axis_rate_limit`. `axis_rate_limit` shapes traffic at a source by stalling it. This block sits at a receiving boundary and checks incoming traffic against a token bucket. A frame that arrives without credit is discarded in full, and the source is never back-pressured for it. Passed frames are forwarded through a registered output stage with skid buffer.

---
 rtl/axis_rate_policer_pkg.sv | 12 +
 rtl/axis_rate_policer_skid.sv | 62 ++++++
 rtl/axis_rate_policer.sv | 163 ++++++++++++++++
 tb/tb_axis_rate_policer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rate_policer_pkg.sv
// Shared types for the AXI4-Stream ingress policer: FSM encoding and config widths.
package axis_rate_policer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int RATE_WIDTH = 8;

endpackage

// File: rtl/axis_rate_policer_skid.sv
// Two-register output stage (output reg + temp reg). Gives full throughput while
// keeping out_ready off any combinational path to in_ready.
module axis_rate_policer_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             ready_reg;
  logic             ready_early;
  logic             out_valid_reg;
  logic             temp_valid;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] temp_data;

  // Ready for next cycle if the consumer drains, or nothing would be left stranded.
  assign ready_early = out_ready || (!temp_valid && (!out_valid_reg || !in_valid));

  assign in_ready  = ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      temp_valid    <= 1'b0;
    end else begin
      ready_reg <= ready_early;
      if (ready_reg) begin
        if (out_ready || !out_valid_reg) begin
          out_valid_reg <= in_valid;
        end else begin
          temp_valid <= in_valid;
        end
      end else if (out_ready) begin
        out_valid_reg <= temp_valid;
        temp_valid    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ready_reg) begin
      if (out_ready || !out_valid_reg) begin
        out_data_reg <= in_data;
      end else begin
        temp_data <= in_data;
      end
    end else if (out_ready) begin
      out_data_reg <= temp_data;
    end
  end

endmodule

// File: rtl/axis_rate_policer.sv
// AXI4-Stream ingress policer: token-bucket check at each frame's first beat;
// frames without credit are discarded whole, passed frames go through a skid stage.
//
// state   | meaning
// IDLE    | waiting for the first beat of a frame
// PASS    | forwarding the rest of an admitted frame
// DROP    | consuming and discarding the rest of a rejected frame
module axis_rate_policer
  import axis_rate_policer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [RATE_WIDTH-1:0] rate_num,
  input  logic [RATE_WIDTH-1:0] rate_denom,
  input  logic [ACC_WIDTH-2:0]  burst_max,
  output logic                  status_frame_pass,
  output logic                  status_frame_drop
);

  localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int EXT_W     = ACC_WIDTH + 2;

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] credit;
  logic signed [ACC_WIDTH-1:0] credit_next;
  logic signed [EXT_W-1:0]     credit_sum;
  logic signed [EXT_W-1:0]     burst_ext;
  logic signed [EXT_W-1:0]     floor_ext;

  logic hs;
  logic credit_ok;
  logic fwd_beat;
  logic pass_next;
  logic drop_next;
  logic ready_int;

  logic [PAYLOAD_W-1:0]  in_payload;
  logic [PAYLOAD_W-1:0]  out_payload;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;

  // Dropped frames are swallowed at full rate regardless of the output side.
  assign s_axis_tready = (state == ST_DROP) ? 1'b1 : ready_int;
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign credit_ok     = !credit[ACC_WIDTH-1];

  always_comb begin
    state_next = state;
    fwd_beat   = 1'b0;
    pass_next  = 1'b0;
    drop_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          if (credit_ok) begin
            fwd_beat  = 1'b1;
            pass_next = 1'b1;
            if (!s_axis_tlast) state_next = ST_PASS;
          end else begin
            drop_next = 1'b1;
            if (!s_axis_tlast) state_next = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        fwd_beat = hs;
        if (hs && s_axis_tlast) state_next = ST_IDLE;
      end
      ST_DROP: begin
        if (hs && s_axis_tlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign burst_ext = {3'b000, burst_max};
  assign floor_ext = {3'b111, {(ACC_WIDTH-1){1'b0}}};

  // Two guard bits keep the sum exact before clamping into [floor, burst_max].
  always_comb begin
    credit_sum  = {{2{credit[ACC_WIDTH-1]}}, credit} + {{(EXT_W-RATE_WIDTH){1'b0}}, rate_num};
    credit_next = credit;
    if (fwd_beat) credit_sum = credit_sum - {{(EXT_W-RATE_WIDTH){1'b0}}, rate_denom};
    if (credit_sum > burst_ext) begin
      credit_next = burst_ext[ACC_WIDTH-1:0];
    end else if (credit_sum < floor_ext) begin
      credit_next = floor_ext[ACC_WIDTH-1:0];
    end else begin
      credit_next = credit_sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      credit            <= '0;
      status_frame_pass <= 1'b0;
      status_frame_drop <= 1'b0;
    end else begin
      state             <= state_next;
      credit            <= credit_next;
      status_frame_pass <= pass_next;
      status_frame_drop <= drop_next;
    end
  end

  assign in_payload = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  axis_rate_policer_skid #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_payload),
    .in_valid (fwd_beat),
    .in_ready (ready_int),
    .out_data (out_payload),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

  assign {out_user, out_dest, out_id, out_last, out_keep, out_data} = out_payload;

  assign m_axis_tdata = out_data;
  assign m_axis_tlast = out_last;
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? out_keep : {KEEP_WIDTH{1'b1}};
  assign m_axis_tid   = (ID_ENABLE != 0)   ? out_id   : {ID_WIDTH{1'b0}};
  assign m_axis_tdest = (DEST_ENABLE != 0) ? out_dest : {DEST_WIDTH{1'b0}};
  assign m_axis_tuser = (USER_ENABLE != 0) ? out_user : {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_rate_policer.sv
// Directed bench for axis_rate_policer: credit ratio, free forwarding, no recovery,
// backpressure, drop isolation and mid-frame reset, with hand-computed expectations.
module tb_axis_rate_policer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic [0:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [7:0]  s_axis_tdest;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic [0:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [7:0]  rate_num;
  logic [7:0]  rate_denom;
  logic [22:0] burst_max;
  logic        status_frame_pass;
  logic        status_frame_drop;

  int n_assert = 0;
  int n_fail   = 0;
  int pass_cnt = 0;
  int drop_cnt = 0;
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  axis_rate_policer dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tid       (s_axis_tid),
    .s_axis_tdest     (s_axis_tdest),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tid       (m_axis_tid),
    .m_axis_tdest     (m_axis_tdest),
    .m_axis_tuser     (m_axis_tuser),
    .rate_num         (rate_num),
    .rate_denom       (rate_denom),
    .burst_max        (burst_max),
    .status_frame_pass(status_frame_pass),
    .status_frame_drop(status_frame_drop)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (status_frame_pass) pass_cnt++;
      if (status_frame_drop) drop_cnt++;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input string tag, input int len, input logic [7:0] base, input logic user,
                            input bit exp_pass, output int first_credit, output int stalls);
    bit hs;
    int waits;
    stalls = 0;
    first_credit = 0;
    for (int b = 0; b < len; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 8'(b);
      s_axis_tlast  = (b == len - 1);
      s_axis_tuser  = user;
      hs = 1'b0;
      waits = 0;
      while (!hs && waits < 64) begin
        @(negedge clk);
        hs = s_axis_tready;
        if (hs && b == 0) first_credit = int'(dut.credit);
        if (!hs) stalls++;
        waits++;
        @(posedge clk); #1;
      end
      check({tag, " handshake"}, 32'(hs), 1);
      if (!hs) break;
      if (b == 0) begin
        check({tag, " pass pulse"}, 32'(status_frame_pass), 32'(exp_pass));
        check({tag, " drop pulse"}, 32'(status_frame_drop), 32'(!exp_pass));
      end
      if (exp_pass) exp_q.push_back({user, s_axis_tlast, s_axis_tdata});
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_output(input string tag);
    check({tag, " beat count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s beat %0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cr, st, pc0, dc0;
    int exp_cr[9] = '{0, -24, -16, -8, 0, -24, -16, -8, 0};
    bit exp_ps[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};

    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b1;
    rate_num = 8'd1; rate_denom = 8'd4; burst_max = '0;
    repeat (3) @(posedge clk); #1;
    check("reset m_tvalid", 32'(m_axis_tvalid), 0);
    check("reset s_tready", 32'(s_axis_tready), 0);
    check("reset pass pulse", 32'(status_frame_pass), 0);
    check("reset drop pulse", 32'(status_frame_drop), 0);
    check("reset credit", int'(dut.credit), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_tready after reset", 32'(s_axis_tready), 1);

    // credit ratio 1/4, 8-beat frames back to back
    pc0 = pass_cnt; dc0 = drop_cnt;
    for (int f = 0; f < 9; f++) begin
      send_frame($sformatf("ratio f%0d", f + 1), 8, 8'((f + 1) * 16), 1'b0, exp_ps[f], cr, st);
      check($sformatf("ratio f%0d first credit", f + 1), cr, exp_cr[f]);
    end
    repeat (4) @(posedge clk); #1;
    check("ratio pass count", pass_cnt - pc0, 3);
    check("ratio drop count", drop_cnt - dc0, 6);
    check_output("ratio");

    // free forwarding
    rate_denom = 8'd0;
    repeat (30) @(posedge clk); #1;
    check("free credit recovered", int'(dut.credit), 0);
    pc0 = pass_cnt; dc0 = drop_cnt;
    for (int f = 0; f < 20; f++)
      send_frame($sformatf("free f%0d", f), int'($urandom_range(1, 8)), 8'($urandom), 1'($urandom), 1'b1, cr, st);
    repeat (4) @(posedge clk); #1;
    check("free pass count", pass_cnt - pc0, 20);
    check("free drop count", drop_cnt - dc0, 0);
    check_output("free");

    // no recovery
    rate_num = 8'd0; rate_denom = 8'd1;
    @(posedge clk); #1;
    send_frame("norecov f1", 4, 8'h40, 1'b0, 1'b1, cr, st);
    for (int f = 2; f <= 5; f++) begin
      send_frame($sformatf("norecov f%0d", f), 5, 8'(f * 16 + 64), 1'b0, 1'b0, cr, st);
      check($sformatf("norecov f%0d stalls", f), st, 0);
    end
    repeat (4) @(posedge clk); #1;
    check("norecov credit", int'(dut.credit), -4);
    check_output("norecov");

    // backpressure on a passed 16-beat frame
    rate_num = 8'd4; rate_denom = 8'd1; burst_max = 23'd100;
    repeat (10) @(posedge clk); #1;
    fork
      send_frame("bp", 16, 8'h80, 1'b0, 1'b1, cr, st);
      begin
        for (int i = 0; i < 4; i++) begin
          m_axis_tready = 1'($urandom);
          @(posedge clk); #1;
        end
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          m_axis_tready = 1'b0;
          @(negedge clk);
          if (i > 0) check($sformatf("bp s_tready stall %0d", i), 32'(s_axis_tready), 0);
          @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
          m_axis_tready = 1'($urandom);
          @(posedge clk); #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    check_output("bp");

    // drop isolation: one passed beat held, then a dropped frame
    m_axis_tready = 1'b0; rate_num = 8'd0; rate_denom = 8'd255;
    @(posedge clk); #1;
    send_frame("iso held", 1, 8'hC5, 1'b0, 1'b1, cr, st);
    send_frame("iso drop", 6, 8'hD0, 1'b0, 1'b0, cr, st);
    check("iso drop stalls", st, 0);
    check("iso held valid", 32'(m_axis_tvalid), 1);
    check("iso held data", 32'(m_axis_tdata), 32'h0C5);
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_output("iso");

    // reset on beat 3 of a passed frame
    rate_num = 8'd4; rate_denom = 8'd1; burst_max = 23'd50;
    repeat (100) @(posedge clk); #1;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 8'hE0;
    @(posedge clk); #1;
    s_axis_tdata = 8'hE1;
    @(posedge clk); #1;
    s_axis_tdata = 8'hE2; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_axis_tvalid = 1'b0;
    check("rst mid m_tvalid", 32'(m_axis_tvalid), 0);
    check("rst mid s_tready", 32'(s_axis_tready), 0);
    check("rst mid credit", int'(dut.credit), 0);
    out_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check("rst mid s_tready rise", 32'(s_axis_tready), 1);
    send_frame("post rst", 3, 8'hF0, 1'b0, 1'b1, cr, st);
    check("post rst first credit", cr, 4);
    repeat (4) @(posedge clk); #1;
    check_output("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
